pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the redirect counter.
REQ-003 Port Clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port Reset, input, 1: synchronous, active-high reset.
REQ-005 Port Stall, input, 1: fetch stall; PC holds while high.
REQ-006 Port BranchTaken, input, 1: one-cycle pulse, branch resolved taken.
REQ-007 Port BranchBase, input, 32: PC+4 of the resolving branch.
REQ-008 Port ShiftedOffset, input, 32: sign-extended immediate already shifted left by 2 (word offset in bytes).
REQ-009 Port PC, output, 32: registered fetch address.
REQ-010 Port PCPlus4, output, 32: combinational PC+4, modulo 2^32.
REQ-011 Port FlushIF, output, 1: registered one-cycle pulse in the cycle the redirected PC first appears.
REQ-012 Port RedirectPending, output, 1: high while state is HOLD.
REQ-013 Port RedirectCount, output, CNT_W: saturating count of applied redirects.

Function
REQ-014 Target SHALL be (BranchBase + ShiftedOffset) mod 2^32 with bits [1:0] forced to 2'b00; wrap-around past 32'hFFFF_FFFC is silent.
REQ-015 FSM SHALL have two states, RUN and HOLD.
REQ-016 RUN, BranchTaken=0, Stall=0: PC <= PC+4 next edge.
REQ-017 RUN, Stall=1, BranchTaken=0: PC holds.
REQ-018 RUN, BranchTaken=1, Stall=0: PC <= target next edge; FlushIF=1 that following cycle; RedirectCount increments; stay RUN.
REQ-019 RUN, BranchTaken=1, Stall=1: target captured into pending register; PC holds; go HOLD.
REQ-020 HOLD, Stall=1: PC and pending register hold; BranchTaken ignored (younger, wrong-path).
REQ-021 HOLD, Stall=0: PC <= pending target next edge; FlushIF=1 that following cycle; RedirectCount increments; go RUN; BranchTaken in this same cycle ignored.
REQ-022 Latency: redirect visible on PC exactly one edge after the cycle in which it is applied (REQ-018/021).
REQ-023 FlushIF SHALL be 0 in every cycle not specified by REQ-018/021.
REQ-024 RedirectCount SHALL saturate at all-ones; no wrap.

Reset
REQ-025 On Reset=1 at a clock edge: PC=RESET_PC, FlushIF=0, state=RUN, RedirectPending=0, pending register=0, RedirectCount=0.
REQ-026 Reset SHALL take priority over all inputs, including a pending redirect in HOLD, which is discarded.

Configuration
REQ-027 Macro PC_JUMP_TARGET_EN, when defined, SHALL add inputs Jump (1) and JumpIndex (26).
REQ-028 With it, Jump=1 SHALL use target {BranchBase[31:28], JumpIndex, 2'b00} under the same RUN/HOLD rules as BranchTaken; Jump and BranchTaken together: Jump wins.
REQ-029 Without it, Jump/JumpIndex ports SHALL be absent and behaviour is REQ-014..024 only.

Verification
REQ-030 Reset with RESET_PC=0, then 3 free cycles -> PC 0,4,8,12; FlushIF=0 throughout.
REQ-031 PC=0x40, BranchTaken with BranchBase=0x44, ShiftedOffset=0x10 -> next PC=0x54, FlushIF pulse 1 cycle, RedirectCount=1.
REQ-032 BranchTaken (BranchBase=0x100, ShiftedOffset=0xFFFFFFF8) with Stall=1 for 3 cycles, second BranchTaken mid-stall -> PC held, RedirectPending=1; after Stall drops PC=0xF8, second branch ignored.
REQ-033 BranchBase=0xFFFFFFFC, ShiftedOffset=0x8 -> PC=0x4 (wrap).
REQ-034 Reset asserted while in HOLD -> PC=RESET_PC, RedirectPending=0, no FlushIF after release.
REQ-035 CNT_W=2, 5 redirects -> RedirectCount sticks at 3.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC register with branch redirect, stall-deferred redirect (RUN/HOLD) and saturating redirect counter.
// Optional PC_JUMP_TARGET_EN adds Jump/JumpIndex pseudo-direct jump targets that take priority over branches.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchBase,
  input  logic [31:0]      ShiftedOffset,
`ifdef PC_JUMP_TARGET_EN
  input  logic             Jump,
  input  logic [25:0]      JumpIndex,
`endif
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             FlushIF,
  output logic             RedirectPending,
  output logic [CNT_W-1:0] RedirectCount
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_pend, w_sum, w_tgt, w_apply_tgt;
  logic r_flush, w_take, w_apply, w_capture;
  logic [CNT_W-1:0] r_cnt;
  assign w_sum = BranchBase + ShiftedOffset;
`ifdef PC_JUMP_TARGET_EN
  assign w_take = Jump | BranchTaken;
  assign w_tgt  = Jump ? {BranchBase[31:28], JumpIndex, 2'b00} : {w_sum[31:2], 2'b00};
`else
  assign w_take = BranchTaken;
  assign w_tgt  = {w_sum[31:2], 2'b00};
`endif
  always_ff @(posedge Clk)
    r_state <= Reset ? RUN : w_next;
  always_comb
    w_next = (r_state == RUN) ? ((w_take && Stall) ? HOLD : RUN) : (Stall ? HOLD : RUN);
  // in HOLD any new branch is younger wrong-path work, so only the pending target matters
  always_comb begin
    w_apply     = (r_state == RUN) ? (w_take && !Stall) : !Stall;
    w_capture   = (r_state == RUN) && w_take && Stall;
    w_apply_tgt = (r_state == HOLD) ? r_pend : w_tgt;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_flush <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_apply ? w_apply_tgt : (Stall ? r_pc : r_pc + 32'd4);
      r_pend  <= w_capture ? w_tgt : r_pend;
      r_flush <= w_apply;
      r_cnt   <= (w_apply && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign PC              = r_pc;
  assign PCPlus4         = r_pc + 32'd4;
  assign FlushIF         = r_flush;
  assign RedirectPending = (r_state == HOLD);
  assign RedirectCount   = r_cnt;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed checks of pc_branch_unit (default and CNT_W=2 instances share stimulus).
module tb_pc_branch_unit;
  logic Clk = 1'b0, Reset = 1'b0, Stall = 1'b0, BranchTaken = 1'b0;
  logic [31:0] BranchBase = '0, ShiftedOffset = '0;
  logic [31:0] PC, PCPlus4, PC2, PCPlus4_2;
  logic FlushIF, RedirectPending, FlushIF2, RedirectPending2;
  logic [15:0] RedirectCount;
  logic [1:0] RedirectCount2;
`ifdef PC_JUMP_TARGET_EN
  logic Jump = 1'b0;
  logic [25:0] JumpIndex = '0;
`endif
  int n = 0, p = 0;
  always #5 Clk = ~Clk;
  pc_branch_unit dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchBase(BranchBase), .ShiftedOffset(ShiftedOffset),
`ifdef PC_JUMP_TARGET_EN
    .Jump(Jump), .JumpIndex(JumpIndex),
`endif
    .PC(PC), .PCPlus4(PCPlus4), .FlushIF(FlushIF),
    .RedirectPending(RedirectPending), .RedirectCount(RedirectCount)
  );
  pc_branch_unit #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchBase(BranchBase), .ShiftedOffset(ShiftedOffset),
`ifdef PC_JUMP_TARGET_EN
    .Jump(Jump), .JumpIndex(JumpIndex),
`endif
    .PC(PC2), .PCPlus4(PCPlus4_2), .FlushIF(FlushIF2),
    .RedirectPending(RedirectPending2), .RedirectCount(RedirectCount2)
  );
  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask
  task automatic branch(input logic [31:0] b, input logic [31:0] o);
    BranchTaken = 1'b1; BranchBase = b; ShiftedOffset = o;
    cyc();
    BranchTaken = 1'b0;
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    n++; if (PC !== 32'h0) $display("FAIL rst_pc got %h exp %h", PC, 32'h0); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL rst_flush got %b exp 0", FlushIF); else p++;
    n++; if (RedirectPending !== 1'b0) $display("FAIL rst_pend got %b exp 0", RedirectPending); else p++;
    n++; if (RedirectCount !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", RedirectCount); else p++;
    n++; if (PCPlus4 !== 32'h4) $display("FAIL rst_pc4 got %h exp %h", PCPlus4, 32'h4); else p++;
  endtask
  task automatic test_free_run;
    logic [31:0] e;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      e = 32'(4 * i);
      n++; if (PC !== e) $display("FAIL free_pc%0d got %h exp %h", i, PC, e); else p++;
      n++; if (FlushIF !== 1'b0) $display("FAIL free_flush%0d got %b exp 0", i, FlushIF); else p++;
    end
  endtask
  task automatic test_branch;
    for (int i = 0; i < 13; i++) cyc();
    n++; if (PC !== 32'h40) $display("FAIL br_pre_pc got %h exp %h", PC, 32'h40); else p++;
    branch(32'h44, 32'h10);
    n++; if (PC !== 32'h54) $display("FAIL br_pc got %h exp %h", PC, 32'h54); else p++;
    n++; if (FlushIF !== 1'b1) $display("FAIL br_flush got %b exp 1", FlushIF); else p++;
    n++; if (RedirectCount !== 16'd1) $display("FAIL br_cnt got %0d exp 1", RedirectCount); else p++;
    cyc();
    n++; if (PC !== 32'h58) $display("FAIL br_next_pc got %h exp %h", PC, 32'h58); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL br_flush_off got %b exp 0", FlushIF); else p++;
  endtask
  task automatic test_stall_hold;
    Stall = 1'b1;
    branch(32'h100, 32'hFFFF_FFF8);
    n++; if (PC !== 32'h58) $display("FAIL hold_pc1 got %h exp %h", PC, 32'h58); else p++;
    n++; if (RedirectPending !== 1'b1) $display("FAIL hold_pend1 got %b exp 1", RedirectPending); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL hold_flush1 got %b exp 0", FlushIF); else p++;
    cyc();
    branch(32'h200, 32'h40);
    n++; if (PC !== 32'h58) $display("FAIL hold_pc3 got %h exp %h", PC, 32'h58); else p++;
    n++; if (RedirectPending !== 1'b1) $display("FAIL hold_pend3 got %b exp 1", RedirectPending); else p++;
    Stall = 1'b0;
    branch(32'h300, 32'h0);
    n++; if (PC !== 32'hF8) $display("FAIL rel_pc got %h exp %h", PC, 32'hF8); else p++;
    n++; if (FlushIF !== 1'b1) $display("FAIL rel_flush got %b exp 1", FlushIF); else p++;
    n++; if (RedirectPending !== 1'b0) $display("FAIL rel_pend got %b exp 0", RedirectPending); else p++;
    n++; if (RedirectCount !== 16'd2) $display("FAIL rel_cnt got %0d exp 2", RedirectCount); else p++;
    cyc();
    n++; if (PC !== 32'hFC) $display("FAIL rel_next_pc got %h exp %h", PC, 32'hFC); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL rel_flush_off got %b exp 0", FlushIF); else p++;
  endtask
  task automatic test_wrap;
    branch(32'hFFFF_FFFC, 32'h8);
    n++; if (PC !== 32'h4) $display("FAIL wrap_pc got %h exp %h", PC, 32'h4); else p++;
    branch(32'hFFFF_FFF8, 32'h4);
    n++; if (PC !== 32'hFFFF_FFFC) $display("FAIL top_pc got %h exp %h", PC, 32'hFFFF_FFFC); else p++;
    n++; if (PCPlus4 !== 32'h0) $display("FAIL top_pc4 got %h exp %h", PCPlus4, 32'h0); else p++;
    cyc();
    n++; if (PC !== 32'h0) $display("FAIL inc_wrap_pc got %h exp %h", PC, 32'h0); else p++;
    branch(32'h20, 32'h3);
    n++; if (PC !== 32'h20) $display("FAIL align_pc got %h exp %h", PC, 32'h20); else p++;
    n++; if (RedirectCount !== 16'd5) $display("FAIL wrap_cnt got %0d exp 5", RedirectCount); else p++;
  endtask
  task automatic test_saturation;
    n++; if (RedirectCount2 !== 2'd3) $display("FAIL sat_cnt5 got %0d exp 3", RedirectCount2); else p++;
    branch(32'h80, 32'h0);
    n++; if (RedirectCount2 !== 2'd3) $display("FAIL sat_cnt6 got %0d exp 3", RedirectCount2); else p++;
    n++; if (RedirectCount !== 16'd6) $display("FAIL wide_cnt6 got %0d exp 6", RedirectCount); else p++;
  endtask
  task automatic test_reset_hold;
    Stall = 1'b1;
    branch(32'h1000, 32'h0);
    n++; if (RedirectPending !== 1'b1) $display("FAIL rh_pend got %b exp 1", RedirectPending); else p++;
    Reset = 1'b1;
    cyc();
    Reset = 1'b0; Stall = 1'b0;
    n++; if (PC !== 32'h0) $display("FAIL rh_pc got %h exp %h", PC, 32'h0); else p++;
    n++; if (RedirectPending !== 1'b0) $display("FAIL rh_pend_clr got %b exp 0", RedirectPending); else p++;
    n++; if (RedirectCount !== 16'd0) $display("FAIL rh_cnt got %0d exp 0", RedirectCount); else p++;
    cyc();
    n++; if (PC !== 32'h4) $display("FAIL rh_pc1 got %h exp %h", PC, 32'h4); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL rh_flush1 got %b exp 0", FlushIF); else p++;
    cyc();
    n++; if (PC !== 32'h8) $display("FAIL rh_pc2 got %h exp %h", PC, 32'h8); else p++;
    n++; if (FlushIF !== 1'b0) $display("FAIL rh_flush2 got %b exp 0", FlushIF); else p++;
  endtask
`ifdef PC_JUMP_TARGET_EN
  task automatic test_jump;
    Jump = 1'b1; JumpIndex = 26'h0000_123;
    branch(32'hA000_0000, 32'h40);
    Jump = 1'b0;
    n++; if (PC !== 32'hA000_048C) $display("FAIL jump_pc got %h exp %h", PC, 32'hA000_048C); else p++;
    n++; if (FlushIF !== 1'b1) $display("FAIL jump_flush got %b exp 1", FlushIF); else p++;
  endtask
`endif
  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_stall_hold();
    test_wrap();
    test_saturation();
    test_reset_hold();
`ifdef PC_JUMP_TARGET_EN
    test_jump();
`endif
    $display("%0d/%0d checks passed", p, n);
    $finish;
  end
endmodule
